// File: rtl/jtdsp16_do_cache_pkg.sv
// jtdsp16_do_cache_pkg: shared state encoding, default cache depth and do_data field decoders
package jtdsp16_do_cache_pkg;
  localparam int DEPTH_DEF = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, REPLAY = 2'd2} state_t;
  function automatic logic [3:0] do_n(input logic [10:0] d);
    return d[10:7];
  endfunction
  function automatic logic [6:0] do_k(input logic [10:0] d);
    return d[6:0];
  endfunction
endpackage

// File: rtl/jtdsp16_do_cache_if.sv
// jtdsp16_do_cache_if: decoder <-> do-loop cache request and fetch-mux signals
interface jtdsp16_do_cache_if;
  logic        cen;
  logic        do_start;
  logic [10:0] do_data;
  logic        stall;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        cache_sel;
  logic        pc_freeze;
  logic        busy;
  modport master (output cen, do_start, do_data, stall, rom_dout,
                  input  cache_dout, cache_sel, pc_freeze, busy);
  modport slave  (input  cen, do_start, do_data, stall, rom_dout,
                  output cache_dout, cache_sel, pc_freeze, busy);
endinterface

// File: rtl/jtdsp16_do_cache_ram.sv
// jtdsp16_do_cache_ram: loop-body register file, sync write gated by cen, async read, async clear
module jtdsp16_do_cache_ram #(
  parameter int DEPTH = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [3:0]  raddr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (cen && we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/jtdsp16_do_cache.sv
// jtdsp16_do_cache: do/redo loop body capture and replay sequencer
// Captures N ROM words, then replays them from the cache while the PC is frozen.
module jtdsp16_do_cache
  import jtdsp16_do_cache_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  jtdsp16_do_cache_if.slave  bus
);
  state_t      st;
  logic [3:0]  n_len, wr_idx, rd_idx;
  logic [6:0]  iter;
  logic        valid, rep, busy;
  logic [3:0]  n;
  logic [6:0]  k;
  logic        last_wr, last_rd;
  assign n       = do_n(bus.do_data);
  assign k       = do_k(bus.do_data);
  assign last_wr = wr_idx == n_len - 4'd1;
  assign last_rd = rd_idx == n_len - 4'd1;
  assign bus.cache_sel = rep;
  assign bus.pc_freeze = rep;
  assign bus.busy      = busy;
  jtdsp16_do_cache_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .cen   (bus.cen),
    .we    (st == FILL && !bus.stall),
    .waddr (wr_idx),
    .raddr (rd_idx),
    .wdata (bus.rom_dout),
    .rdata (bus.cache_dout)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st     <= IDLE;
      n_len  <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      iter   <= '0;
      valid  <= 1'b0;
      rep    <= 1'b0;
      busy   <= 1'b0;
    end else if (bus.cen) begin
      case (st)
        IDLE:
          if (bus.do_start && n != 4'd0) begin
            st     <= FILL;
            n_len  <= n;
            wr_idx <= '0;
            valid  <= 1'b0;
            iter   <= k > 7'd1 ? k - 7'd1 : 7'd0;
            busy   <= 1'b1;
          end else if (bus.do_start && valid) begin
            st     <= REPLAY;
            rd_idx <= '0;
            iter   <= k == 7'd0 ? 7'd1 : k;
            rep    <= 1'b1;
            busy   <= 1'b1;
          end
        FILL:
          if (!bus.stall) begin
            wr_idx <= wr_idx + 4'd1;
            if (last_wr) begin
              valid  <= 1'b1;
              rd_idx <= '0;
              st     <= iter == 7'd0 ? IDLE : REPLAY;
              rep    <= iter != 7'd0;
              busy   <= iter != 7'd0;
            end
          end
        REPLAY:
          if (!bus.stall) begin
            rd_idx <= last_rd ? 4'd0 : rd_idx + 4'd1;
            if (last_rd) begin
              iter <= iter - 7'd1;
              // final pass ends: hand the fetch slot back to ROM
              if (iter == 7'd1) begin
                st   <= IDLE;
                rep  <= 1'b0;
                busy <= 1'b0;
              end
            end
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// tb_jtdsp16_do_cache: slot-level model of do/redo loops checked against the cache every cycle
module tb_jtdsp16_do_cache;
  typedef struct { logic sel; logic [15:0] w; } slot_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  jtdsp16_do_cache_if bus();
  jtdsp16_do_cache dut (.clk(clk), .rstn(rstn), .bus(bus));
  logic [15:0] rom [1024];
  logic [9:0]  pc = '0;
  assign bus.rom_dout = rom[pc];
  always @(posedge clk) if (rstn && bus.cen && !bus.stall && !bus.pc_freeze) pc <= pc + 10'd1;
  slot_t       q[$];
  logic [15:0] body[$];
  bit          mvalid = 1'b0;
  int          total = 0, passed = 0, frz_cnt = 0;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask
  // expected decoder slots for a do/redo sampled at the last edge
  task automatic model_load(input int n, input int k);
    int reps;
    if (q.size() != 0) return;
    reps = (k == 0) ? 1 : k;
    if (n != 0) begin
      body.delete();
      for (int i = 0; i < n; i++) body.push_back(rom[pc + 10'(i)]);
      mvalid = 1'b1;
      for (int i = 0; i < n; i++) q.push_back('{1'b0, body[i]});
      for (int r = 1; r < reps; r++)
        for (int i = 0; i < n; i++) q.push_back('{1'b1, body[i]});
    end else if (mvalid)
      for (int r = 0; r < reps; r++)
        for (int i = 0; i < body.size(); i++) q.push_back('{1'b1, body[i]});
  endtask
  always @(negedge clk) if (rstn) begin
    logic [15:0] dec;
    dec = bus.cache_sel ? bus.cache_dout : bus.rom_dout;
    if (bus.cen && bus.pc_freeze) frz_cnt++;
    if (q.size() != 0) begin
      check("slot_sel", {15'd0, bus.cache_sel}, {15'd0, q[0].sel});
      check("slot_freeze", {15'd0, bus.pc_freeze}, {15'd0, q[0].sel});
      check("slot_word", dec, q[0].w);
      check("slot_busy", {15'd0, bus.busy}, 16'd1);
      if (bus.cen && !bus.stall) void'(q.pop_front());
    end else begin
      check("idle_busy", {15'd0, bus.busy}, 16'd0);
      check("idle_sel", {15'd0, bus.cache_sel}, 16'd0);
      check("idle_freeze", {15'd0, bus.pc_freeze}, 16'd0);
    end
  end
  task automatic issue(input int n, input int k);
    logic [3:0] nn;
    logic [6:0] kk;
    nn = n[3:0];
    kk = k[6:0];
    bus.cen = 1'b1;
    bus.do_start = 1'b1;
    bus.do_data = {nn, kk};
    @(posedge clk); #1;
    bus.do_start = 1'b0;
    model_load(n, k);
  endtask
  task automatic wait_idle(input bit rnd_cen);
    int c = 0;
    while ((q.size() != 0 || bus.busy) && c < 800) begin
      bus.cen = rnd_cen ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    bus.cen = 1'b1;
    if (c >= 800) check("idle_timeout", 16'd0, 16'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 16'h0123) ^ 16'h5A5A;
    bus.cen = 1'b1;
    bus.do_start = 1'b0;
    bus.do_data = '0;
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", {15'd0, bus.cache_sel}, 16'd0);
    check("rst_freeze", {15'd0, bus.pc_freeze}, 16'd0);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    check("rst_dout", bus.cache_dout, 16'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    issue(0, 4);
    repeat (3) @(posedge clk);
    #1;
    check("redo_after_rst_busy", {15'd0, bus.busy}, 16'd0);
    frz_cnt = 0;
    issue(3, 4);
    wait_idle(1'b0);
    check("do3x4_freeze_slots", 16'(frz_cnt), 16'd9);
    frz_cnt = 0;
    issue(0, 2);
    wait_idle(1'b1);
    check("redo2_cache_slots", 16'(frz_cnt), 16'd6);
    frz_cnt = 0;
    issue(3, 4);
    @(posedge clk); #1;
    bus.stall = 1'b1;
    @(posedge clk); #1;
    bus.stall = 1'b0;
    wait_idle(1'b0);
    check("stall_freeze_slots", 16'(frz_cnt), 16'd9);
    frz_cnt = 0;
    issue(15, 1);
    wait_idle(1'b0);
    check("do15x1_freeze_slots", 16'(frz_cnt), 16'd0);
    frz_cnt = 0;
    issue(0, 1);
    wait_idle(1'b0);
    check("redo_after_k1_slots", 16'(frz_cnt), 16'd15);
    frz_cnt = 0;
    issue(1, 127);
    wait_idle(1'b0);
    check("do1x127_freeze_slots", 16'(frz_cnt), 16'd126);
    issue(0, 50);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_sel", {15'd0, bus.cache_sel}, 16'd0);
    check("arst_freeze", {15'd0, bus.pc_freeze}, 16'd0);
    check("arst_busy", {15'd0, bus.busy}, 16'd0);
    check("arst_dout", bus.cache_dout, 16'd0);
    q.delete();
    mvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    issue(0, 3);
    repeat (3) @(posedge clk);
    #1;
    check("redo_after_arst_busy", {15'd0, bus.busy}, 16'd0);
    frz_cnt = 0;
    issue(4, 2);
    issue(2, 5);
    wait_idle(1'b0);
    check("start_in_fill_slots", 16'(frz_cnt), 16'd4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
